// File: rtl/router_1xn.sv
// router_1xn: routes length/parity-framed byte packets from one source into NCH byte FIFOs.
// Optional ROUTER_SOFT_RESET_EN: a channel left unread for TIMEOUT cycles is flushed.
module router_1xn #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic [7:0]       data_in,
  input  logic [NCH-1:0]   read_enb,
  output logic [NCH-1:0]   vld_out,
  output logic [8*NCH-1:0] data_out,
  output logic             busy,
  output logic             err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_STALL = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DROP  = 3'd5;

  logic [2:0] state_q, state_nxt;
  logic [7:0] hdr_q, hdr_nxt;
  logic [7:0] par_q, par_nxt;
  logic [7:0] hold_q, hold_nxt;
  logic [6:0] cnt_q, cnt_nxt;
  logic       hold_last_q, hold_last_nxt;
  logic       perr_q, perr_nxt;
  logic       err_nxt;

  logic       wr_en_c;
  logic [1:0] wr_ch_c;
  logic [7:0] wr_data_c;

  logic [7:0]    mem [NCH][DEPTH];
  logic [PW-1:0] wr_ptr_q [NCH];
  logic [PW-1:0] rd_ptr_q [NCH];
  logic [PW-1:0] wr_ptr_nxt [NCH];
  logic [PW-1:0] rd_ptr_nxt [NCH];

  logic [NCH-1:0] empty_c, full_c, rd_fire_c, wr_fire_c, flush_c, hit_in_c, hit_hdr_c;
  logic           in_addr_ok_c, in_tgt_empty_c, tgt_empty_c, tgt_full_c, tgt_flush_c;

  // Per-channel FIFO status and address decode
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      empty_c[i]   = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_c[i]    = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                     (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      rd_fire_c[i] = read_enb[i] & ~empty_c[i];
      hit_in_c[i]  = (data_in[1:0] == 2'(i));
      hit_hdr_c[i] = (hdr_q[1:0] == 2'(i));
    end
  end

  assign in_addr_ok_c   = |hit_in_c;
  assign in_tgt_empty_c = |(empty_c & hit_in_c);
  assign tgt_empty_c    = |(empty_c & hit_hdr_c);
  // A full FIFO that is being read this edge can still take a byte
  assign tgt_full_c     = |(full_c & ~rd_fire_c & hit_hdr_c);
  assign tgt_flush_c    = |(flush_c & hit_hdr_c);

`ifdef ROUTER_SOFT_RESET_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      flush_c[i] = ~empty_c[i] & ~read_enb[i] & (idle_q[i] == TW'(TIMEOUT - 1));
    end
  end

  // Counts cycles a channel holds data with no read strobe
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) idle_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (empty_c[i] || read_enb[i] || flush_c[i]) idle_q[i] <= '0;
        else                                         idle_q[i] <= idle_q[i] + TW'(1);
      end
    end
  end
`else
  assign flush_c = '0;
`endif

  // Next-state and datapath decode
  always_comb begin
    state_nxt     = state_q;
    hdr_nxt       = hdr_q;
    par_nxt       = par_q;
    cnt_nxt       = cnt_q;
    hold_nxt      = hold_q;
    hold_last_nxt = hold_last_q;
    perr_nxt      = perr_q;
    err_nxt       = err;
    wr_en_c       = 1'b0;
    wr_ch_c       = hdr_q[1:0];
    wr_data_c     = hdr_q;
    case (state_q)
      S_IDLE: begin
        wr_ch_c = data_in[1:0];
        if (pkt_valid) begin
          hdr_nxt  = data_in;
          par_nxt  = data_in;
          cnt_nxt  = '0;
          perr_nxt = 1'b0;
          if (!in_addr_ok_c) begin
            state_nxt = S_DROP;
          end else begin
            err_nxt = 1'b0;
            if (in_tgt_empty_c) begin
              wr_en_c   = 1'b1;
              wr_data_c = data_in;
              state_nxt = S_LOAD;
            end else begin
              state_nxt = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (tgt_empty_c) begin
          wr_en_c   = 1'b1;
          wr_data_c = hdr_q;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pkt_valid) begin
          par_nxt = par_q ^ data_in;
          cnt_nxt = (cnt_q == 7'h7f) ? cnt_q : cnt_q + 7'd1;
        end else begin
          perr_nxt = (par_q != data_in);
        end
        if (tgt_flush_c) begin
          state_nxt = pkt_valid ? S_DROP : S_IDLE;
        end else if (tgt_full_c) begin
          hold_nxt      = data_in;
          hold_last_nxt = ~pkt_valid;
          state_nxt     = S_STALL;
        end else begin
          wr_en_c   = 1'b1;
          wr_data_c = data_in;
          state_nxt = pkt_valid ? S_LOAD : S_CHECK;
        end
      end
      S_STALL: begin
        if (tgt_flush_c) begin
          state_nxt = hold_last_q ? S_IDLE : S_DROP;
        end else if (!tgt_full_c) begin
          wr_en_c   = 1'b1;
          wr_data_c = hold_q;
          state_nxt = hold_last_q ? S_CHECK : S_LOAD;
        end
      end
      S_CHECK: begin
        err_nxt   = perr_q | (cnt_q != 7'(hdr_q[7:2]));
        state_nxt = S_IDLE;
      end
      S_DROP: begin
        if (!pkt_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM and packet datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      par_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      perr_q      <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      hdr_q       <= hdr_nxt;
      par_q       <= par_nxt;
      cnt_q       <= cnt_nxt;
      hold_q      <= hold_nxt;
      hold_last_q <= hold_last_nxt;
      perr_q      <= perr_nxt;
      err         <= err_nxt;
      busy        <= (state_nxt == S_WAIT) || (state_nxt == S_STALL) || (state_nxt == S_CHECK);
    end
  end

  // Pointer updates; a flush wins over any write on the same edge
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr_fire_c[i]  = wr_en_c & (wr_ch_c == 2'(i)) & ~flush_c[i];
      wr_ptr_nxt[i] = flush_c[i] ? '0 : wr_ptr_q[i] + PW'(wr_fire_c[i]);
      rd_ptr_nxt[i] = flush_c[i] ? '0 : rd_ptr_q[i] + PW'(rd_fire_c[i]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      vld_out  <= '0;
      data_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= wr_ptr_nxt[i];
        rd_ptr_q[i] <= rd_ptr_nxt[i];
        vld_out[i]  <= (wr_ptr_nxt[i] != rd_ptr_nxt[i]);
        if (rd_fire_c[i]) data_out[8*i +: 8] <= mem[i][rd_ptr_q[i][AW-1:0]];
      end
    end
  end

  // FIFO storage, no reset needed since pointers define contents
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCH; i++) begin
      if (wr_fire_c[i]) mem[i][wr_ptr_q[i][AW-1:0]] <= wr_data_c;
    end
  end

endmodule

// File: tb/tb_router_1xn.sv
// Scoreboard bench for router_1xn: directed packets plus randomized traffic with random reads.
`timescale 1ns/1ps
module tb_router_1xn;
  localparam int unsigned NCH     = 3;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 30;
  localparam int          LIMIT   = 2000;

  logic             clock = 1'b0;
  logic             resetn;
  logic             pkt_valid;
  logic [7:0]       data_in;
  logic [NCH-1:0]   read_enb;
  logic [NCH-1:0]   vld_out;
  logic [8*NCH-1:0] data_out;
  logic             busy;
  logic             err;

  typedef logic [7:0] byte_q_t [$];
  byte_q_t exp_q [NCH];
  bit      err_exp_q [$];

  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt = 0;
  int err_chk  = 0;

  bit             rd_random = 1'b0;
  logic [NCH-1:0] rd_fixed  = '0;

  router_1xn #(.NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb(read_enb), .vld_out(vld_out), .data_out(data_out), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp_v, $time);
    end
  endtask

  // Read strobe driver, changed well clear of the sampling edge
  initial begin
    read_enb = '0;
    forever begin
      @(posedge clock);
      #2;
      read_enb = rd_random ? NCH'($urandom) : rd_fixed;
    end
  end

  // Data monitor: each accepted read must produce the next expected byte of that channel
  initial begin
    forever begin
      logic [NCH-1:0] fire;
      logic [7:0]     e;
      @(negedge clock);
      fire = read_enb & vld_out;
      @(posedge clock);
      #1;
      if (resetn) begin
        for (int c = 0; c < NCH; c++) begin
          if (fire[c]) begin
            if (exp_q[c].size() == 0) begin
              check($sformatf("ch%0d unexpected byte", c), 32'(data_out[8*c +: 8]), 32'hFFFF_FFFF);
            end else begin
              e = exp_q[c].pop_front();
              check($sformatf("ch%0d data", c), 32'(data_out[8*c +: 8]), 32'(e));
            end
          end
        end
      end
    end
  end

  // Error monitor: checks err once per completed routed packet
  initial begin
    forever begin
      @(negedge clock);
      if (done_cnt > err_chk) begin
        err_chk++;
        if (err_exp_q.size() == 0) check("err with no expectation", 32'(err), 32'hFFFF_FFFF);
        else                       check("err", 32'(err), 32'(err_exp_q.pop_front()));
      end
    end
  end

  // Sends one packet; expectations come from the packet framing rules, not from DUT state
  task automatic send_packet(input logic [7:0] hdr, input int n_pay, input int bad_kind,
                             input int stop_after, input bit chk_clear,
                             output bit busy_seen, output int first_busy);
    logic [7:0] pkt [$];
    logic [7:0] x, b;
    int ch, w, last;
    x = hdr;
    pkt.push_back(hdr);
    for (int k = 0; k < n_pay; k++) begin
      b = 8'($urandom);
      pkt.push_back(b);
      x ^= b;
    end
    pkt.push_back((bad_kind == 1) ? (x ^ 8'h01) : x);
    ch = int'(hdr[1:0]);
    if (ch < int'(NCH)) begin
      x = 8'h00;
      foreach (pkt[k]) begin
        exp_q[ch].push_back(pkt[k]);
        x ^= pkt[k];
      end
      if (stop_after == 0) err_exp_q.push_back((x != 8'h00) || (n_pay != int'(hdr[7:2])));
    end
    busy_seen  = 1'b0;
    first_busy = -1;
    last = pkt.size() - 1;
    for (int k = 0; k <= last; k++) begin
      if (stop_after > 0 && k >= stop_after) break;
      pkt_valid = (k != last);
      data_in   = pkt[k];
      if (busy) begin
        busy_seen = 1'b1;
        if (first_busy < 0) first_busy = k;
      end
      w = 0;
      while (busy && w < LIMIT) begin
        @(negedge clock);
        w++;
      end
      if (w >= LIMIT) begin
        check("busy release timeout", 32'(w), 32'(0));
        break;
      end
      @(negedge clock);
      if (chk_clear && k == 0) check("err cleared by header", 32'(err), 32'(0));
    end
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    if (stop_after == 0) begin
      w = 0;
      while (busy && w < LIMIT) begin
        @(negedge clock);
        w++;
      end
      if (w >= LIMIT) check("packet end timeout", 32'(w), 32'(0));
      if (ch < int'(NCH)) done_cnt++;
      @(negedge clock);
    end
  endtask

  task automatic drain();
    int w, pending;
    rd_random = 1'b0;
    rd_fixed  = '1;
    w = 0;
    do begin
      pending = 0;
      for (int c = 0; c < NCH; c++) pending += exp_q[c].size();
      if (pending != 0) begin
        @(negedge clock);
        w++;
      end
    end while (pending != 0 && w < LIMIT);
    repeat (3) @(negedge clock);
    for (int c = 0; c < NCH; c++) check($sformatf("ch%0d drained", c), 32'(exp_q[c].size()), 32'(0));
    check("vld_out after drain", 32'(vld_out), 32'(0));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   bs;
    int   fb, len, npay, kind;
    logic [1:0] addr;

    resetn    = 1'b0;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    repeat (3) @(negedge clock);
    check("reset busy", 32'(busy), 32'(0));
    check("reset err", 32'(err), 32'(0));
    check("reset vld_out", 32'(vld_out), 32'(0));
    check("reset data_out", 32'(data_out), 32'(0));
    resetn = 1'b1;
    @(negedge clock);

    // Streaming packet to ch0 while it is read every cycle
    rd_fixed = 3'b001;
    repeat (2) @(negedge clock);
    send_packet(8'h38, 14, 0, 0, 1'b0, bs, fb);
    check("0x38 busy during bytes", 32'(bs), 32'(0));
    drain();

    // ch1 left unread: FIFO fills, busy rises after the 9th byte, released by reading
    rd_fixed = '0;
    repeat (2) @(negedge clock);
    fork
      send_packet(8'h39, 14, 0, 0, 1'b0, bs, fb);
      begin
        repeat (30) @(negedge clock);
        rd_fixed = 3'b010;
      end
    join
    check("0x39 busy seen", 32'(bs), 32'(1));
    check("0x39 bytes before busy", 32'(fb), 32'(9));
    drain();

    // Corrupted parity sets err, next accepted header clears it
    send_packet(8'h0A, 2, 1, 0, 1'b0, bs, fb);
    check("err after bad parity", 32'(err), 32'(1));
    send_packet(8'h08, 2, 0, 0, 1'b1, bs, fb);
    drain();

    // Address beyond NCH is dropped without stalling or writing
    rd_fixed = '0;
    repeat (2) @(negedge clock);
    send_packet(8'h07, 1, 0, 0, 1'b0, bs, fb);
    check("drop busy", 32'(bs), 32'(0));
    check("drop vld_out", 32'(vld_out), 32'(0));
    rd_fixed = '1;
    send_packet(8'h0D, 3, 0, 0, 1'b0, bs, fb);
    drain();

    // Reset mid-packet discards everything
    rd_fixed = '0;
    repeat (2) @(negedge clock);
    send_packet(8'h38, 14, 0, 6, 1'b0, bs, fb);
    check("vld before mid reset", 32'(vld_out[0]), 32'(1));
    resetn = 1'b0;
    #1;
    check("mid reset vld_out", 32'(vld_out), 32'(0));
    check("mid reset data_out", 32'(data_out), 32'(0));
    check("mid reset busy", 32'(busy), 32'(0));
    check("mid reset err", 32'(err), 32'(0));
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    err_exp_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    rd_fixed = '1;
    send_packet(8'h08, 2, 0, 0, 1'b0, bs, fb);
    drain();

    // Unread ch2 data: kept forever, or flushed when the soft-reset timer is built in
    rd_fixed = '0;
    repeat (2) @(negedge clock);
    send_packet(8'h0A, 2, 0, 0, 1'b0, bs, fb);
    check("ch2 loaded", 32'(vld_out[2]), 32'(1));
    repeat (40) @(negedge clock);
`ifdef ROUTER_SOFT_RESET_EN
    check("ch2 flushed after timeout", 32'(vld_out[2]), 32'(0));
    exp_q[2].delete();
`else
    check("ch2 held without timeout", 32'(vld_out[2]), 32'(1));
`endif
    drain();

    // Randomized traffic with random read strobes
    rd_random = 1'b1;
    for (int p = 0; p < 30; p++) begin
      len  = (p % 10 == 9) ? 40 : int'($urandom_range(1, 20));
      addr = 2'($urandom_range(0, 3));
      kind = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
      npay = len;
      if (kind == 2) npay = (len > 1 && $urandom_range(0, 1) == 1) ? len - 1 : len + 1;
      send_packet({6'(len), addr}, npay, kind, 0, 1'b0, bs, fb);
    end
    drain();
    check("err checks all consumed", 32'(err_exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/router_1xn.md
ROUTER_1XN -- requirements
Module: router_1xn

Interface
REQ-001 SHALL have parameter NCH, default 3, number of output channels (1..4).
REQ-002 SHALL have parameter DEPTH, default 16, per-channel FIFO depth in bytes (power of two, 4..64).
REQ-003 SHALL have parameter TIMEOUT, default 30, read-idle cycles before channel soft reset.
REQ-004 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pkt_valid  input  1  high during header and payload bytes, low on parity byte.
REQ-007 SHALL have port data_in  input  8  packet byte stream.
REQ-008 SHALL have port read_enb  input  NCH  per-channel read strobe.
REQ-009 SHALL have port vld_out  output  NCH  bit i high when FIFO i is non-empty.
REQ-010 SHALL have port data_out  output  8*NCH  channel i on bits [8i+7:8i].
REQ-011 SHALL have port busy  output  1  source must hold data_in while high.
REQ-012 SHALL have port err  output  1  parity or length error on last packet.

Function
REQ-013 Packet SHALL be: header {len[7:2], addr[1:0]}, len payload bytes (1..63), one parity byte = XOR of header and payloads.
REQ-014 Source SHALL present a new byte only on edges where busy=0; router SHALL sample data_in only on edges where busy=0 and state accepts data.
REQ-015 FSM states SHALL be IDLE, WAIT_EMPTY, LOAD_DATA, FULL_STALL, CHECK_PARITY, DROP; busy SHALL be a Moore output, 1 in WAIT_EMPTY, FULL_STALL, CHECK_PARITY, else 0.
REQ-016 IDLE + pkt_valid=1: header captured; addr>=NCH -> DROP; target FIFO empty -> header written, LOAD_DATA; else -> WAIT_EMPTY.
REQ-017 WAIT_EMPTY: when target FIFO empty, write captured header, -> LOAD_DATA; data_in not sampled.
REQ-018 LOAD_DATA, pkt_valid=1: write byte, update running parity, increment payload count.
REQ-019 LOAD_DATA, target FIFO full at sampling edge: byte into hold register, -> FULL_STALL; on first non-full cycle hold byte written, -> LOAD_DATA; no byte lost or duplicated.
REQ-020 LOAD_DATA, pkt_valid=0: byte is parity, written to FIFO (via FULL_STALL if full), -> CHECK_PARITY.
REQ-021 CHECK_PARITY (1 cycle): err <= (parity mismatch) OR (payload count != len); -> IDLE.
REQ-022 err SHALL hold until the next header is accepted, then clear to 0.
REQ-023 DROP: consume bytes with busy=0, write nothing, leave err unchanged; -> IDLE on the edge pkt_valid=0 is sampled.
REQ-024 Read: read_enb[i]=1 and FIFO i non-empty -> data_out_i updated with head byte at next edge (1-cycle latency); otherwise data_out_i holds.
REQ-025 read_enb[i] on an empty FIFO SHALL be ignored; simultaneous read and write on a full FIFO SHALL both succeed.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL use an extra pointer bit; occupancy never exceeds DEPTH.
REQ-027 Channels SHALL read independently while another channel is being written.

Reset
REQ-028 resetn=0 SHALL immediately force FSM to IDLE, empty all FIFOs, clear parity, counters and hold register, including mid-packet.
REQ-029 During reset: busy=0, err=0, vld_out=0, data_out=0.
REQ-030 A packet interrupted by reset SHALL be lost; the first byte after release with pkt_valid=1 SHALL be treated as a header.

Configuration
REQ-031 With ROUTER_SOFT_RESET_EN defined: per-channel counter counts cycles with vld_out[i]=1 and read_enb[i]=0, clears on any read; at TIMEOUT FIFO i SHALL flush next edge.
REQ-032 If the flushed channel is the current write target, FSM SHALL go to DROP for the packet remainder and err SHALL not be set.
REQ-033 Without ROUTER_SOFT_RESET_EN: no counters; unread data SHALL be held indefinitely.

Verification
REQ-034 Header 0x38 (len 14, addr 0), 14 payloads, correct parity, read_enb[0] held -> 16 bytes out on ch0 in order, err=0, busy never high.
REQ-035 Header 0x39 (len 14, addr 1) with read_enb[1]=0 and DEPTH=8 -> busy high at 9th byte, released on reading; all 16 bytes intact.
REQ-036 Header 0x0A (len 2, addr 2), parity byte XOR'd with 0x01 -> err=1 after CHECK_PARITY, cleared on next accepted header.
REQ-037 Header 0x07 (addr 3) with NCH=3 -> no writes, busy=0, vld_out=000, next packet routed normally.
REQ-038 resetn low mid-payload of ch0 packet -> vld_out=0, data_out=0 immediately; following packet 0x08 routed correctly.
REQ-039 ROUTER_SOFT_RESET_EN, ch2 loaded, read_enb[2]=0 for 30 cycles -> vld_out[2] falls on cycle 31; without macro stays high.
